// File: rtl/picobello_pkg.sv
// Shared types for the multicast system address map (SAM) and the decoder response.
package picobello_pkg;

  localparam int unsigned SamNumRules  = 16;
  localparam int unsigned AddrWidth    = 48;
  localparam int unsigned CoordWidth   = 4;
  localparam int unsigned MaskLenMax   = 6;
  localparam int unsigned MaskOutWidth = 16;
  localparam int unsigned ErrCntWidth  = 16;

  typedef logic [CoordWidth-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    logic   port_id;
  } id_t;

  typedef struct packed {
    logic [MaskLenMax-1:0] offset;
    logic [MaskLenMax-1:0] len;
  } mask_sel_t;

  typedef struct packed {
    id_t                  idx;
    logic [AddrWidth-1:0] start_addr;
    logic [AddrWidth-1:0] end_addr;
    mask_sel_t            mask_x;
    mask_sel_t            mask_y;
  } sam_multicast_rule_t;

  localparam int unsigned RuleWidth = $bits(sam_multicast_rule_t);

  typedef struct packed {
    id_t                     idx;
    logic [MaskOutWidth-1:0] mask_x;
    logic [MaskOutWidth-1:0] mask_y;
    logic                    is_mcast;
    logic                    dec_err;
  } mcast_dec_rsp_t;

  // (mask >> offset) limited to len bits; len >= MaskOutWidth keeps all output bits.
  function automatic logic [MaskOutWidth-1:0] extract_mask(logic [AddrWidth-1:0] mask,
                                                           mask_sel_t            sel);
    logic [MaskOutWidth-1:0] m;
    m = MaskOutWidth'(mask >> sel.offset);
    if (sel.len < MaskLenMax'(MaskOutWidth)) begin
      m &= ~({MaskOutWidth{1'b1}} << sel.len);
    end
    return m;
  endfunction

endpackage

// File: rtl/picobello_mcast_rsp_fifo.sv
// Two-entry in-order buffer for decoded responses; ready_o is registered so it
// never depends combinationally on the consumer side.
module picobello_mcast_rsp_fifo
  import picobello_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           push_i,
  input  mcast_dec_rsp_t data_i,
  input  logic           pop_i,
  output mcast_dec_rsp_t data_o,
  output logic           full_o,
  output logic           empty_o,
  output logic           ready_o
);

  mcast_dec_rsp_t mem_q [2];
  logic           wr_ptr_q, rd_ptr_q;
  logic [1:0]     cnt_q, cnt_d;
  logic           ready_q;
  logic           push, pop;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign push    = push_i & ~full_o;
  assign pop     = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign ready_o = ready_q;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 2'd1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q   <= cnt_d;
      ready_q <= (cnt_d != 2'd2);
    end
  end

endmodule

// File: rtl/picobello_mcast_addr_decoder.sv
// Decodes address + multicast mask against the SAM into destination id and X/Y masks.
// Define PICOBELLO_MCAST_STRICT_EN to flag mask bits outside a rule's mask window.
module picobello_mcast_addr_decoder
  import picobello_pkg::*;
#(
  parameter int unsigned NumRules = SamNumRules
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumRules*RuleWidth-1:0]    sam_i,
  input  logic                             req_valid_i,
  output logic                             req_ready_o,
  input  logic [AddrWidth-1:0]             req_addr_i,
  input  logic [AddrWidth-1:0]             req_mask_i,
  output logic                             rsp_valid_o,
  input  logic                             rsp_ready_i,
  output logic [2*CoordWidth:0]            dst_idx_o,
  output logic [MaskOutWidth-1:0]          dst_mask_x_o,
  output logic [MaskOutWidth-1:0]          dst_mask_y_o,
  output logic                             is_mcast_o,
  output logic                             dec_err_o,
  output logic [ErrCntWidth-1:0]           err_cnt_o
);

  logic                  [AddrWidth-1:0] base;
  logic                                  is_mcast;
  logic                                  hit;
  logic                                  stray;
  logic                                  dec_err;
  sam_multicast_rule_t                   cur;
  sam_multicast_rule_t                   rule;
  mcast_dec_rsp_t                        rsp_d, rsp_q;
  logic                                  push, pop, fifo_full, fifo_empty, fifo_ready;
  logic                  [ErrCntWidth-1:0] err_cnt_q;

  assign base     = req_addr_i & ~req_mask_i;
  assign is_mcast = |req_mask_i;

  // First matching rule in index order wins on overlap.
  always_comb begin
    hit  = 1'b0;
    rule = '0;
    cur  = '0;
    for (int unsigned r = 0; r < NumRules; r++) begin
      cur = sam_multicast_rule_t'(sam_i[r*RuleWidth +: RuleWidth]);
      if (!hit && (base >= cur.start_addr) && (base < cur.end_addr)) begin
        hit  = 1'b1;
        rule = cur;
      end
    end
  end

`ifdef PICOBELLO_MCAST_STRICT_EN
  logic [MaskLenMax:0]  win_hi;
  logic [AddrWidth-1:0] win_mask;
  assign win_hi   = {1'b0, rule.mask_x.offset} + {1'b0, rule.mask_x.len};
  // Window [mask_y.offset, mask_x.offset+mask_x.len); shifts past the width saturate.
  assign win_mask = ~({AddrWidth{1'b1}} << win_hi) & ({AddrWidth{1'b1}} << rule.mask_y.offset);
  assign stray    = is_mcast & |(req_mask_i & ~win_mask);
`else
  assign stray    = 1'b0;
`endif

  assign dec_err = !hit
                 || (is_mcast && (rule.mask_x.len == '0) && (rule.mask_y.len == '0))
                 || stray;

  always_comb begin
    rsp_d          = '0;
    rsp_d.is_mcast = is_mcast;
    rsp_d.dec_err  = dec_err;
    if (!dec_err) begin
      rsp_d.idx = rule.idx;
      if (is_mcast) begin
        rsp_d.mask_x = extract_mask(req_mask_i, rule.mask_x);
        rsp_d.mask_y = extract_mask(req_mask_i, rule.mask_y);
      end
    end
  end

  assign push = req_valid_i & fifo_ready;
  assign pop  = ~fifo_empty & rsp_ready_i;

  picobello_mcast_rsp_fifo i_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (rsp_d),
    .pop_i   (pop),
    .data_o  (rsp_q),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .ready_o (fifo_ready)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_q <= '0;
    end else if (push && dec_err && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ErrCntWidth'(1);
    end
  end

  // fifo_full is implied by ~fifo_ready; kept for observability of the buffer state.
  logic unused_full;
  assign unused_full = fifo_full;

  assign req_ready_o  = fifo_ready;
  assign rsp_valid_o  = ~fifo_empty;
  assign dst_idx_o    = rsp_q.idx;
  assign dst_mask_x_o = rsp_q.mask_x;
  assign dst_mask_y_o = rsp_q.mask_y;
  assign is_mcast_o   = rsp_q.is_mcast;
  assign dec_err_o    = rsp_q.dec_err;
  assign err_cnt_o    = err_cnt_q;

endmodule

// File: doc/picobello_mcast_addr_decoder.md
Name: picobello_mcast_addr_decoder

Overview:
Pipelined address-to-destination decoder that consumes the packed multicast system address map (per-rule idx, start/end address, mask_x/mask_y offset/len) from picobello_pkg. Sits between a narrow AXI AW/AR request source and the FlooNoC chimney's routing-info injection.
Per request (address + multicast mask), it produces the destination tile id, X/Y multicast masks, a multicast flag and a decode error.
It is a single registered stage with a 2-entry output buffer, sustaining one request per cycle.

Parameters:
NumRules, 16, number of SAM rules (SamNumRules)
AddrWidth, 48, request address / mask width
CoordWidth, 4, width of each id_t x/y field
MaskLenMax, 6, width of mask_sel_t offset/len fields and max X/Y mask width (2^6-1 bits not required; mask outputs are 16 bits)
MaskOutWidth, 16, width of dst_mask_x_o / dst_mask_y_o
ErrCntWidth, 16, width of saturating error counter

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
sam_i  in  NumRules*rule_t  packed multicast rule table; quasi-static, changed only while idle
req_valid_i  in  1  request valid
req_ready_o  out  1  request ready
req_addr_i  in  AddrWidth  target address
req_mask_i  in  AddrWidth  multicast mask; 0 = unicast
rsp_valid_o  out  1  decoded result valid
rsp_ready_i  in  1  downstream ready
dst_idx_o  out  2*CoordWidth+1  destination id (x, y, port_id)
dst_mask_x_o  out  MaskOutWidth  X multicast mask
dst_mask_y_o  out  MaskOutWidth  Y multicast mask
is_mcast_o  out  1  request is multicast
dec_err_o  out  1  decode error for this result
err_cnt_o  out  ErrCntWidth  saturating count of decode errors

Behaviour:
- Reset: every output is 0. The buffer is empty, so rsp_valid_o=0 and req_ready_o=1 one cycle after reset release. err_cnt_o=0.
- Handshake: valid/ready. valid must not drop and payload must stay stable until ready. req_ready_o = buffer not full, registered and not combinationally dependent on rsp_ready_i.
- Decode, combinational on accept:
  - base = req_addr_i & ~req_mask_i.
  - Match rule r when start_addr <= base < end_addr. The lowest r wins on overlap.
- Multicast, when req_mask_i != 0:
  - is_mcast=1.
  - mask_x = (req_mask_i >> mask_x.offset) & ((1<<mask_x.len)-1), zero-extended to MaskOutWidth. mask_y is formed the same way.
  - len=0 yields a 0 mask.
- Errors (dec_err=1, dst_idx=0, masks=0):
  - no rule matches;
  - multicast to a rule with mask_x.len==0 and mask_y.len==0.
- Unicast outputs zero masks.
- Latency: accepted in cycle N, the result is visible with rsp_valid_o=1 in cycle N+1. Throughput is 1/cycle with continuous rsp_ready_i.
- Output buffer: 2-entry FIFO in order, with write and read pointers plus a 2-bit occupancy.
  - Simultaneous push and pop when full is not possible, because ready is low.
  - Simultaneous push and pop when occupancy is 1 keeps occupancy at 1.
- err_cnt_o increments on the accept cycle of an erroneous request and saturates at all-ones (no wrap).
- Reset asserted mid-operation flushes the buffer and clears the counter immediately (async). In-flight results are dropped.

Optional Feature:
PICOBELLO_MCAST_STRICT_EN:
- When defined, a multicast mask with any bit set outside [mask_y.offset, mask_x.offset+mask_x.len) of the matched rule is also a decode error. This condition counts in err_cnt_o.
- When not defined, those stray bits are ignored: they are cleared in base only, and the request is not flagged.

Decomposition:
- picobello_pkg: mask_sel_t, sam_multicast_rule_t, id_t re-export, and a mcast_dec_rsp_t struct {idx, mask_x, mask_y, is_mcast, dec_err}.
- Sub-module picobello_mcast_rsp_fifo: 2-entry mcast_dec_rsp_t buffer with full/empty flags.
- Decode logic stays in the top level.

Test Plan:
Fixture table: rule0 = idx{x:1,y:0}, [0x2000_0000, 0x2004_0000), mask_y{18,2}, mask_x{20,2}. rule1 = idx{x:0,y:0}, [0x7000_0000, 0x7010_0000), len 0.
- Unicast, addr 0x2000_0100, mask 0, rsp_ready_i=1 → next cycle rsp_valid=1, idx{1,0}, masks 0, is_mcast=0, dec_err=0.
- Multicast, addr 0x2000_0000, mask 0x0030_0000 → idx{1,0}, mask_x=0x3, mask_y=0x0, is_mcast=1.
- Unmapped address 0x1000_0000 → dec_err=1, idx 0, err_cnt_o 0→1.
- Multicast to rule1, addr 0x7000_0000, mask 0x0004_0000 → dec_err=1.
- Backpressure: rsp_ready_i=0 with 3 back-to-back requests → req_ready_o low after 2 accepts. Releasing ready drains the results in order, 1 per cycle.
- With PICOBELLO_MCAST_STRICT_EN, mask 0x1000_0000 on rule0 → dec_err=1. Without the macro → no error, idx{1,0}.
